// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS data-store path.
// Optional feature macro used by the store buffer: STORE_BUF_COALESCE_EN.
package mips_mem_pkg;

  localparam int AW_DEF   = 32;
  localparam int DW_DEF   = 32;
  localparam int WORD_OFS = 2;

  typedef struct packed {
    logic [AW_DEF-1:0] addr;
    logic [DW_DEF-1:0] data;
  } store_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } drain_state_t;

  function automatic logic misaligned(input logic [WORD_OFS-1:0] lsb);
    return lsb != '0;
  endfunction

endpackage

// File: rtl/mips_store_buffer_if.sv
// Write-request handshake between the store buffer (master) and data memory (slave).
interface mips_store_buffer_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();

  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ack;

  modport master (
    output mem_req,
    output mem_addr,
    output mem_wdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack
  );

endinterface

// File: rtl/store_buf_fifo.sv
// In-order storage for buffered stores: entry array, wrapping pointers, occupancy.
// All entries are visible in parallel so the top level can do forwarding lookups.
module store_buf_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  input  logic          ovr,
  input  logic [DW-1:0] ovr_data,
  output logic [AW-1:0] addr_q [DEPTH],
  output logic [DW-1:0] data_q [DEPTH],
  output logic [PW-1:0] head,
  output logic [PW-1:0] tail,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [PW-1:0] head_reg, tail_reg;
  logic [CW-1:0] count_reg;
  logic [PW-1:0] youngest;

  assign youngest = tail_reg - PW'(1);

  // Entry contents need no reset: validity comes solely from head/count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_reg] <= push_addr;
      data_q[tail_reg] <= push_data;
    end else if (ovr) begin
      data_q[youngest] <= ovr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + PW'(1);
      if (pop)  head_reg <= head_reg + PW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = head_reg;
  assign tail  = tail_reg;
  assign count = count_reg;
  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);

endmodule

// File: rtl/mips_store_buffer.sv
// Posted-write store buffer: accepts CPU stores, forwards youngest matching data to loads,
// drains in order over a req/ack handshake. STORE_BUF_COALESCE_EN merges stores to the youngest entry.
module mips_store_buffer
  import mips_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cpu_we,
  input  logic [AW-1:0]       cpu_addr,
  input  logic [DW-1:0]       cpu_wdata,
  output logic                cpu_stall,
  input  logic [AW-1:0]       cpu_raddr,
  output logic                fwd_hit,
  output logic [DW-1:0]       fwd_data,
  mips_store_buffer_if.master mem,
  output logic [CW-1:0]       count,
  output logic                empty,
  output logic                full,
  output logic                align_err
);

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head, tail;
  logic          push, pop, coalesce;
  logic          align_err_reg;
  logic [DEPTH-1:0] word_match;
  drain_state_t  state_reg, state_next;
  logic          unused_raddr_lsb;

  assign unused_raddr_lsb = ^cpu_raddr[WORD_OFS-1:0];

  store_buf_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_addr (cpu_addr),
    .push_data (cpu_wdata),
    .pop       (pop),
    .ovr       (coalesce),
    .ovr_data  (cpu_wdata),
    .addr_q    (addr_q),
    .data_q    (data_q),
    .head      (head),
    .tail      (tail),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

`ifdef STORE_BUF_COALESCE_EN
  logic [PW-1:0] youngest;
  assign youngest = tail - PW'(1);
  // With a single entry under an active request, the youngest entry is the one
  // being written to memory, so its data must not change.
  assign coalesce = cpu_we && !empty
                 && (addr_q[youngest][AW-1:WORD_OFS] == cpu_addr[AW-1:WORD_OFS])
                 && !((count == CW'(1)) && mem.mem_req);
`else
  logic unused_tail;
  assign unused_tail = ^tail;
  assign coalesce    = 1'b0;
`endif

  assign push      = cpu_we && !full && !coalesce;
  assign cpu_stall = cpu_we && full && !coalesce;
  assign pop       = mem.mem_req && mem.mem_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      align_err_reg <= 1'b0;
    end else if ((push || coalesce) && misaligned(cpu_addr[WORD_OFS-1:0])) begin
      align_err_reg <= 1'b1;
    end
  end
  assign align_err = align_err_reg;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
      assign word_match[gi] = (addr_q[gi][AW-1:WORD_OFS] == cpu_raddr[AW-1:WORD_OFS]);
    end
  endgenerate

  // Walk entries oldest to youngest so the last valid match (youngest) wins.
  always_comb begin
    logic [PW-1:0] idx;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = head;
    for (int a = 0; a < DEPTH; a++) begin
      idx = head + PW'(a);
      if ((CW'(a) < count) && word_match[idx]) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (!empty) state_next = REQ;
      REQ:     if (mem.mem_ack && (count <= CW'(1))) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign mem.mem_req   = (state_reg == REQ);
  assign mem.mem_addr  = mem.mem_req ? addr_q[head] : '0;
  assign mem.mem_wdata = mem.mem_req ? data_q[head] : '0;

endmodule

// File: tb/tb_mips_store_buffer.sv
// Self-checking bench for mips_store_buffer: vector table, directed corner cases, random vs queue model.
module tb_mips_store_buffer;
  import mips_mem_pkg::*;

`ifdef STORE_BUF_COALESCE_EN
  localparam bit COAL = 1'b1;
`else
  localparam bit COAL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, cpu_raddr = '0;
  logic        cpu_stall, fwd_hit, empty, full, align_err;
  logic [31:0] fwd_data;
  logic [2:0]  count;

  int checks = 0;
  int failures = 0;
  logic [31:0] seen_addr[$];
  logic [31:0] seen_data[$];

  mips_store_buffer_if #(.AW(32), .DW(32)) mem_bus ();

  mips_store_buffer #(.DEPTH(4), .AW(32), .DW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_stall (cpu_stall),
    .cpu_raddr (cpu_raddr),
    .fwd_hit   (fwd_hit),
    .fwd_data  (fwd_data),
    .mem       (mem_bus),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .align_err (align_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr, data, raddr;
    logic        exp_stall, exp_hit;
    logic [31:0] exp_fdata;
    int          exp_count;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Record the handshake that completes on the coming edge, then advance past it.
  task automatic step();
    if (mem_bus.mem_req && mem_bus.mem_ack) begin
      seen_addr.push_back(mem_bus.mem_addr);
      seen_data.push_back(mem_bus.mem_wdata);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
    cpu_we = we; cpu_addr = a; cpu_wdata = d;
    #1;
  endtask

  task automatic do_reset();
    cpu_we = 0; mem_bus.mem_ack = 0; cpu_raddr = '0;
    #2 reset = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b1;
    seen_addr.delete(); seen_data.delete();
    #1;
  endtask

  task automatic wait_req(input int budget);
    for (int i = 0; i < budget && !mem_bus.mem_req; i++) step();
    chk("wait_req", {31'd0, mem_bus.mem_req}, 32'd1);
  endtask

  task automatic drain(input int budget);
    mem_bus.mem_ack = 1'b1;
    #1;
    for (int i = 0; i < budget && !(empty && !mem_bus.mem_req); i++) step();
    mem_bus.mem_ack = 1'b0;
    #1;
    chk("drain_done", {31'd0, empty}, 32'd1);
  endtask

  task automatic chk_seen(input string name, input logic [31:0] exp_a[$]);
    chk({name, "_len"}, seen_addr.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < seen_addr.size(); i++)
      chk(name, seen_addr[i], exp_a[i]);
  endtask

  vec_t tbl[8];
  store_entry_t q[$];

  initial begin
    int c1;
    c1 = COAL ? 1 : 2;
    tbl[0] = '{1, 80, 5, 82, 0, 0, 0, 1};
    tbl[1] = '{1, 80, 9, 82, 0, 1, 5, c1};
    tbl[2] = '{0, 0,  0, 82, 0, 1, 9, c1};
    tbl[3] = '{0, 0,  0, 88, 0, 0, 0, c1};
    tbl[4] = '{1, 0,  1, 0,  0, 0, 0, c1 + 1};
    tbl[5] = '{1, 4,  2, 0,  0, 1, 1, c1 + 2};
    tbl[6] = '{1, 8,  3, 4,  !COAL, 1, 2, 4};
    tbl[7] = '{0, 0,  0, 80, 0, 1, 9, 4};

    mem_bus.mem_ack = 1'b0;

    // Reset state and single store
    do_reset();
    chk("rst_count", count, 0);
    chk("rst_empty", {31'd0, empty}, 1);
    chk("rst_full", {31'd0, full}, 0);
    chk("rst_req", {31'd0, mem_bus.mem_req}, 0);
    chk("rst_maddr", mem_bus.mem_addr, 0);
    chk("rst_mwdata", mem_bus.mem_wdata, 0);
    chk("rst_align", {31'd0, align_err}, 0);
    mem_bus.mem_ack = 1'b1;
    drive(1, 84, 7);
    step();
    drive(0, 0, 0);
    wait_req(3);
    chk("t1_addr", mem_bus.mem_addr, 84);
    chk("t1_data", mem_bus.mem_wdata, 7);
    step();
    chk("t1_empty", {31'd0, empty}, 1);
    chk("t1_req_low", {31'd0, mem_bus.mem_req}, 0);

    // Fill, stall on full, one ack releases the held store
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 32'(i * 4), 32'(i + 16));
      step();
    end
    chk("t2_full", {31'd0, full}, 1);
    chk("t2_count", count, 4);
    drive(1, 16, 20);
    chk("t2_stall", {31'd0, cpu_stall}, 1);
    step();
    chk("t2_count_held", count, 4);
    wait_req(3);
    mem_bus.mem_ack = 1'b1;
    #1;
    chk("t2_stall_ack", {31'd0, cpu_stall}, 1);
    step();
    mem_bus.mem_ack = 1'b0;
    #1;
    chk("t2_count_pop", count, 3);
    chk("t2_unstall", {31'd0, cpu_stall}, 0);
    step();
    drive(0, 0, 0);
    chk("t2_count_refill", count, 4);
    drain(30);
    chk_seen("t2_order", '{0, 4, 8, 12, 16});

    // Vector table: forwarding and occupancy with memory held off
    do_reset();
    for (int i = 0; i < 8; i++) begin
      cpu_raddr = tbl[i].raddr;
      drive(tbl[i].we, tbl[i].addr, tbl[i].data);
      chk($sformatf("vec%0d_stall", i), {31'd0, cpu_stall}, {31'd0, tbl[i].exp_stall});
      chk($sformatf("vec%0d_hit", i), {31'd0, fwd_hit}, {31'd0, tbl[i].exp_hit});
      chk($sformatf("vec%0d_fdata", i), fwd_data, tbl[i].exp_fdata);
      step();
      chk($sformatf("vec%0d_count", i), count, 32'(tbl[i].exp_count));
    end
    drive(0, 0, 0);

    // Push and pop in the same edge keep count
    do_reset();
    drive(1, 0, 1); step();
    drive(1, 4, 2); step();
    drive(0, 0, 0);
    wait_req(3);
    chk("t4_count2", count, 2);
    mem_bus.mem_ack = 1'b1;
    drive(1, 8, 3);
    step();
    drive(0, 0, 0);
    chk("t4_count_same", count, 2);
    drain(20);
    chk_seen("t4_order", '{0, 4, 8});

    // Asynchronous reset mid-request
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'(i * 4 + 64), 32'(i)); step();
    end
    drive(0, 0, 0);
    wait_req(3);
    chk("t5_count3", count, 3);
    #2 reset = 1'b0;
    #1;
    chk("t5_req_drop", {31'd0, mem_bus.mem_req}, 0);
    chk("t5_count0", count, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("t5_empty", {31'd0, empty}, 1);

    // Misaligned store is buffered unchanged and sets the sticky flag
    do_reset();
    drive(1, 86, 1); step();
    chk("align_set", {31'd0, align_err}, 1);
    drive(1, 0, 2); step();
    drive(0, 0, 0);
    drain(20);
    chk("align_sticky", {31'd0, align_err}, 1);
    chk_seen("align_order", '{86, 0});

`ifdef STORE_BUF_COALESCE_EN
    do_reset();
    drive(1, 0, 1); step();
    drive(0, 0, 0);
    wait_req(3);
    drive(1, 80, 5); step();
    drive(1, 80, 9); step();
    drive(0, 0, 0);
    chk("t6_count", count, 2);
    drain(20);
    chk_seen("t6_order", '{0, 80});
    if (seen_data.size() == 2) chk("t6_data", seen_data[1], 9);
    else chk("t6_data_len", seen_data.size(), 2);
`endif

    // Randomized run against a queue model
    do_reset();
    q.delete();
    begin
      bit m_align = 0;
      int pops = 0;
      for (int cyc = 0; cyc < 800; cyc++) begin
        logic        we, ack, coal, stall, hit, hs;
        logic [31:0] a, d, fd;
        we  = 1'($urandom_range(0, 1));
        ack = ($urandom_range(0, 2) != 0);
        a   = 32'($urandom_range(0, 7) * 4) + (($urandom_range(0, 15) == 0) ? 32'd2 : 32'd0);
        d   = $urandom;
        cpu_raddr = 32'($urandom_range(0, 9) * 4) + 32'($urandom_range(0, 3));
        mem_bus.mem_ack = ack;
        drive(we, a, d);

        coal = 1'b0;
        if (COAL && we && q.size() > 0)
          coal = (q[q.size()-1].addr[31:2] == a[31:2]) && !(q.size() == 1 && mem_bus.mem_req);
        stall = we && (q.size() == 4) && !coal;
        hit = 1'b0; fd = '0;
        for (int i = q.size() - 1; i >= 0; i--)
          if (!hit && q[i].addr[31:2] == cpu_raddr[31:2]) begin hit = 1'b1; fd = q[i].data; end

        chk("rnd_count", count, q.size());
        chk("rnd_full", {31'd0, full}, {31'd0, q.size() == 4});
        chk("rnd_empty", {31'd0, empty}, {31'd0, q.size() == 0});
        chk("rnd_stall", {31'd0, cpu_stall}, {31'd0, stall});
        chk("rnd_hit", {31'd0, fwd_hit}, {31'd0, hit});
        chk("rnd_fdata", fwd_data, fd);
        chk("rnd_align", {31'd0, align_err}, {31'd0, m_align});
        if (mem_bus.mem_req) begin
          if (q.size() > 0) begin
            chk("rnd_maddr", mem_bus.mem_addr, q[0].addr);
            chk("rnd_mdata", mem_bus.mem_wdata, q[0].data);
          end else begin
            chk("rnd_req_when_empty", {31'd0, mem_bus.mem_req}, 0);
          end
        end

        hs = mem_bus.mem_req && ack;
        if (hs && q.size() > 0) begin void'(q.pop_front()); pops++; end
        if (coal) q[q.size()-1].data = d;
        else if (we && !stall) q.push_back('{addr: a, data: d});
        if ((coal || (we && !stall)) && a[1:0] != 2'b00) m_align = 1'b1;
        step();
      end
      chk("rnd_drained_some", {31'd0, pops > 0}, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
